ntt_mul_scheduler: RTL and testbench
====================================

// Module: ntt_mul_scheduler
// PURPOSE
//  Sequencer for NTT-domain polynomial multiplication (h = f*g in R_q, q=3329, 128 degree-1 base cases).
//  Streams coefficient pairs of f and g from two pair-wide RAMs and gamma values from the zeta ROM.
//  Drives one shared base-case multiplier (ntt_basecase_mul) and writes h pairs back to RAM.
//  Sits between the Kyber top-level controller (start/done) and the polynomial RAM banks.
// PARAMETERS
//  COEF_W   16   bits per coefficient field (values < 3329)
//  N_PAIR   128  base-case pairs per polynomial
//  MUL_LAT  2    pipeline stages inside ntt_basecase_mul (>=1)
// PORTS
//  clk           in   1          rising-edge clock
//  rst           in   1          synchronous active-high reset
//  start         in   1          begin a 128-pair pass (sampled in IDLE only)
//  busy          out  1          high from cycle after accepted start until done
//  done          out  1          one-cycle pulse after last h write
//  ab_rd_en      out  1          read strobe to f, g and zeta memories (1-cycle read latency, hold data when low)
//  ab_rd_addr    out  7          pair index i; also the zeta ROM address
//  f_rd_data     in   2*COEF_W   {f[2i+1], f[2i]}
//  g_rd_data     in   2*COEF_W   {g[2i+1], g[2i]}
//  zeta_rd_data  in   COEF_W     gamma_i for pair i
//  h_wr_valid    out  1          write request
//  h_wr_ready    in   1          write accepted when valid&ready
//  h_wr_addr     out  7          pair index
//  h_wr_data     out  2*COEF_W   {h[2i+1], h[2i]}, upper bits of each field zero
// BEHAVIOUR
//  Reset: state=IDLE; busy, done, ab_rd_en, h_wr_valid = 0; ab_rd_addr, h_wr_addr, h_wr_data = 0.
//  FSM: IDLE -start-> RUN (issue reads 0..127) -last read issued-> DRAIN -last write accepted-> DONE -> IDLE.
//  DONE lasts one cycle (done=1, busy=0). start while busy or in DONE is ignored.
//  Pipeline: read issue -> data (+1) -> MUL_LAT stages -> h_wr_valid. No stall: start at cycle 0,
//   first write at cycle 2+MUL_LAT, last at 129+MUL_LAT, done at 130+MUL_LAT.
//  Backpressure: advance = !h_wr_valid | h_wr_ready. All stages, the read address and ab_rd_en freeze when !advance.
//   h_wr_valid/addr/data held stable until accepted. Each address 0..127 is written exactly once, in order.
//  Math (per pair): h0 = f0*g0 + f1*g1*gamma; h1 = f0*g1 + f1*g0; all mod 3329, fully reduced to [0,3328].
//   Products are 24-bit; the sum is reduced by Barrett (k=26), no Montgomery factor. Inputs are < 3329.
//  Rst mid-pass: the next cycle is IDLE, all in-flight results are discarded and no further writes are issued.
//  Counters: 7-bit read index and 7-bit write index. No wrap: index 127 terminates its phase.
// CONFIGURATION
//  NTT_MUL_ACC_EN defined: adds ports acc (in 1, sampled with start), h_rd_data (in 2*COEF_W, read with ab_rd_en at ab_rd_addr).
//   With acc=1, h_new = (h_old + f*g) mod q per field. With acc=0, h_new = f*g.
//   h_old travels through the pipeline alongside the pair and uses the same latency.
//  Not defined: no acc/h_rd_data ports; h_new = f*g always.
// STRUCTURE
//  Package ntt_mul_pkg: KYBER_Q=3329, BARRETT_V=20159, BARRETT_K=26, N_PAIR, coef_t/pair_t typedefs,
//   FSM state enum {IDLE,RUN,DRAIN,DONE}, function mod_q_add().
//  Sub-module ntt_basecase_mul: MUL_LAT-deep pipeline with enable (advance). Inputs f pair, g pair, gamma; output h pair.
//  The top holds the FSM, indices, valid shift register and the write handshake.
// TESTING
//  T1: pair0 f={0,1}, g={7,5} (fields {hi,lo}), gamma=17 -> h pair0 = {7,5}; done is 1 at cycle 132 (MUL_LAT=2).
//  T2: pair3 f={1,0}, g={1,0}, gamma=17 -> h pair3 = {0,17}. Same with gamma=3312 (-17) -> {0,3312}.
//  T3: all fields 3328, gamma=17 -> every h pair = {2,18}. Checks max-width reduction.
//  T4: random f/g with the real gamma table; h_wr_ready low for cycles 20-29 and every other cycle after 100
//   -> 128 writes, addresses 0..127 in order, data matches the golden model.
//  T5: rst at cycle 60 -> busy=0 and h_wr_valid=0 the next cycle, no further writes; new start -> full correct pass.
//  T6 (NTT_MUL_ACC_EN): h_old=3000, f*g=500 per field, acc=1 -> 171; acc=0 -> 500.

Source files
------------

// File: rtl/ntt_mul_pkg.sv
// Shared types, constants and modular helpers for the NTT base-case multiply sequencer.
package ntt_mul_pkg;

  localparam int unsigned COEF_W    = 16;
  localparam int unsigned N_PAIR    = 128;
  localparam int unsigned IDX_W     = 7;
  localparam int unsigned KYBER_Q   = 3329;
  localparam int unsigned BARRETT_V = 20159;
  localparam int unsigned BARRETT_K = 26;
  localparam int unsigned PROD_W    = 26;
  localparam int unsigned RED_W     = PROD_W + 1;
  localparam int unsigned BAR_W     = PROD_W + 16;
  localparam int unsigned SUM_W     = COEF_W + 1;

  typedef logic [COEF_W-1:0] coef_t;

  typedef struct packed {
    coef_t hi;
    coef_t lo;
  } pair_t;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  function automatic coef_t mod_q_add(input coef_t a, input coef_t b);
    logic [SUM_W-1:0] s;
    s = {1'b0, a} + {1'b0, b};
    if (s >= SUM_W'(KYBER_Q)) s = s - SUM_W'(KYBER_Q);
    return COEF_W'(s);
  endfunction

  // V is rounded up, so the quotient estimate may be one too large; fix by adding q back.
  function automatic coef_t barrett_reduce(input logic [PROD_W-1:0] x);
    logic [BAR_W-1:0] t;
    logic [RED_W-1:0] qm;
    logic [RED_W-1:0] r;
    t  = BAR_W'(x) * BAR_W'(BARRETT_V);
    qm = RED_W'(t >> BARRETT_K) * RED_W'(KYBER_Q);
    if (qm > {1'b0, x}) r = {1'b0, x} + RED_W'(KYBER_Q) - qm;
    else                r = {1'b0, x} - qm;
    return COEF_W'(r);
  endfunction

endpackage

// File: rtl/ntt_basecase_mul.sv
// Degree-1 base-case product in Z_q[X]/(X^2-gamma); result delayed through MUL_LAT enabled stages.
// NTT_MUL_ACC_EN adds an accumulate input that folds an old h pair into the result.
module ntt_basecase_mul
  import ntt_mul_pkg::*;
#(
  parameter int unsigned MUL_LAT = 2
) (
  input  logic  clk,
  input  logic  rst,
  input  logic  i_en,
  input  pair_t i_f,
  input  pair_t i_g,
  input  coef_t i_gamma,
`ifdef NTT_MUL_ACC_EN
  input  logic  i_acc,
  input  pair_t i_h_old,
`endif
  output pair_t o_h
);

  logic [PROD_W-1:0] w_x0;
  logic [PROD_W-1:0] w_x1;
  coef_t             w_t11;
  pair_t             w_h;
  pair_t             r_pipe [MUL_LAT];

  always_comb begin
    w_t11  = barrett_reduce(PROD_W'(i_f.hi) * PROD_W'(i_g.hi));
    w_x0   = PROD_W'(i_f.lo) * PROD_W'(i_g.lo) + PROD_W'(w_t11) * PROD_W'(i_gamma);
    w_x1   = PROD_W'(i_f.lo) * PROD_W'(i_g.hi) + PROD_W'(i_f.hi) * PROD_W'(i_g.lo);
    w_h.lo = barrett_reduce(w_x0);
    w_h.hi = barrett_reduce(w_x1);
`ifdef NTT_MUL_ACC_EN
    if (i_acc) begin
      w_h.lo = mod_q_add(w_h.lo, i_h_old.lo);
      w_h.hi = mod_q_add(w_h.hi, i_h_old.hi);
    end
`endif
  end

  // Result delay line; retiming is expected to spread the arithmetic across it.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < MUL_LAT; i++) r_pipe[i] <= '0;
    end else if (i_en) begin
      r_pipe[0] <= w_h;
      for (int i = 1; i < MUL_LAT; i++) r_pipe[i] <= r_pipe[i-1];
    end
  end

  assign o_h = r_pipe[MUL_LAT-1];

endmodule

// File: rtl/ntt_mul_scheduler.sv
// Streams f/g/gamma pairs through one base-case multiplier and writes h pairs back with backpressure.
// NTT_MUL_ACC_EN adds acc/h_rd_data ports for h += f*g accumulation.
module ntt_mul_scheduler
  import ntt_mul_pkg::*;
#(
  parameter int unsigned MUL_LAT = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  output logic                busy,
  output logic                done,
  output logic                ab_rd_en,
  output logic [IDX_W-1:0]    ab_rd_addr,
  input  logic [2*COEF_W-1:0] f_rd_data,
  input  logic [2*COEF_W-1:0] g_rd_data,
  input  logic [COEF_W-1:0]   zeta_rd_data,
`ifdef NTT_MUL_ACC_EN
  input  logic                acc,
  input  logic [2*COEF_W-1:0] h_rd_data,
`endif
  output logic                h_wr_valid,
  input  logic                h_wr_ready,
  output logic [IDX_W-1:0]    h_wr_addr,
  output logic [2*COEF_W-1:0] h_wr_data
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_PAIR - 1);

  state_t           r_state, w_next;
  logic             r_busy, r_done, r_rd_en;
  logic [IDX_W-1:0] r_rd_addr, r_wr_addr;
  logic             w_busy_d, w_done_d, w_rd_en_d;
  logic [IDX_W-1:0] w_rd_addr_d, w_wr_addr_d;
  logic [MUL_LAT:0] r_vld;
  logic             w_adv, w_wr_fire;
  logic             r_hold_vld;
  pair_t            r_hold_f, r_hold_g, w_f, w_g, w_h;
  coef_t            r_hold_z, w_z;
`ifdef NTT_MUL_ACC_EN
  logic             r_acc, w_acc_d;
  pair_t            r_hold_h, w_h_old;
`endif

  assign w_adv     = !r_vld[MUL_LAT] || h_wr_ready;
  assign w_wr_fire = r_vld[MUL_LAT] && h_wr_ready;

  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next      = r_state;
    w_rd_en_d   = r_rd_en;
    w_rd_addr_d = r_rd_addr;
    w_wr_addr_d = r_wr_addr;
`ifdef NTT_MUL_ACC_EN
    w_acc_d     = r_acc;
`endif
    case (r_state)
      IDLE: if (start) begin
        w_next      = RUN;
        w_rd_en_d   = 1'b1;
        w_rd_addr_d = '0;
        w_wr_addr_d = '0;
`ifdef NTT_MUL_ACC_EN
        w_acc_d     = acc;
`endif
      end
      RUN: if (w_adv) begin
        if (r_rd_addr == LAST_IDX) begin
          w_next    = DRAIN;
          w_rd_en_d = 1'b0;
        end else begin
          w_rd_addr_d = r_rd_addr + IDX_W'(1);
        end
      end
      DONE:    w_next = IDLE;
      default: ;
    endcase
    if (w_wr_fire && (r_state == RUN || r_state == DRAIN)) begin
      if (r_wr_addr == LAST_IDX) begin
        if (r_state == DRAIN) w_next = DONE;
      end else begin
        w_wr_addr_d = r_wr_addr + IDX_W'(1);
      end
    end
    w_busy_d = (w_next == RUN) || (w_next == DRAIN);
    w_done_d = (w_next == DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_rd_en   <= 1'b0;
      r_rd_addr <= '0;
      r_wr_addr <= '0;
`ifdef NTT_MUL_ACC_EN
      r_acc     <= 1'b0;
`endif
    end else begin
      r_busy    <= w_busy_d;
      r_done    <= w_done_d;
      r_rd_en   <= w_rd_en_d;
      r_rd_addr <= w_rd_addr_d;
      r_wr_addr <= w_wr_addr_d;
`ifdef NTT_MUL_ACC_EN
      r_acc     <= w_acc_d;
`endif
    end
  end

  // The frozen read strobe keeps re-reading memory, so fresh read data is parked on the first stall cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_vld      <= '0;
      r_hold_vld <= 1'b0;
      r_hold_f   <= '0;
      r_hold_g   <= '0;
      r_hold_z   <= '0;
`ifdef NTT_MUL_ACC_EN
      r_hold_h   <= '0;
`endif
    end else if (w_adv) begin
      r_vld      <= {r_vld[MUL_LAT-1:0], r_rd_en};
      r_hold_vld <= 1'b0;
    end else if (r_vld[0] && !r_hold_vld) begin
      r_hold_vld <= 1'b1;
      r_hold_f   <= f_rd_data;
      r_hold_g   <= g_rd_data;
      r_hold_z   <= zeta_rd_data;
`ifdef NTT_MUL_ACC_EN
      r_hold_h   <= h_rd_data;
`endif
    end
  end

  assign w_f = r_hold_vld ? r_hold_f : pair_t'(f_rd_data);
  assign w_g = r_hold_vld ? r_hold_g : pair_t'(g_rd_data);
  assign w_z = r_hold_vld ? r_hold_z : zeta_rd_data;
`ifdef NTT_MUL_ACC_EN
  assign w_h_old = r_hold_vld ? r_hold_h : pair_t'(h_rd_data);
`endif

  ntt_basecase_mul #(.MUL_LAT(MUL_LAT)) u_mul (
    .clk     (clk),
    .rst     (rst),
    .i_en    (w_adv),
    .i_f     (w_f),
    .i_g     (w_g),
    .i_gamma (w_z),
`ifdef NTT_MUL_ACC_EN
    .i_acc   (r_acc),
    .i_h_old (w_h_old),
`endif
    .o_h     (w_h)
  );

  assign busy       = r_busy;
  assign done       = r_done;
  assign ab_rd_en   = r_rd_en;
  assign ab_rd_addr = r_rd_addr;
  assign h_wr_valid = r_vld[MUL_LAT];
  assign h_wr_addr  = r_wr_addr;
  assign h_wr_data  = w_h;

endmodule

// File: tb/tb_ntt_mul_scheduler.sv
// Scoreboard bench for ntt_mul_scheduler; the accumulate scenario builds only with NTT_MUL_ACC_EN.
module tb_ntt_mul_scheduler;

  localparam int MUL_LAT = 2;
  localparam int Q       = 3329;

  typedef struct {
    int          addr;
    logic [31:0] data;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        busy, done, ab_rd_en, h_wr_valid;
  logic        h_wr_ready = 1'b1;
  logic [6:0]  ab_rd_addr, h_wr_addr;
  logic [31:0] f_rd_data = '0;
  logic [31:0] g_rd_data = '0;
  logic [15:0] zeta_rd_data = '0;
  logic [31:0] h_wr_data;
`ifdef NTT_MUL_ACC_EN
  logic        acc = 1'b0;
  logic [31:0] h_rd_data = '0;
  logic [31:0] h_mem [128];
`endif

  logic [31:0] f_mem [128];
  logic [31:0] g_mem [128];
  logic [15:0] z_mem [128];
  logic [31:0] h_got [128];
  exp_t        sb_q [$];
  int          checks = 0;
  int          failures = 0;

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (ab_rd_en) begin
      f_rd_data    <= f_mem[ab_rd_addr];
      g_rd_data    <= g_mem[ab_rd_addr];
      zeta_rd_data <= z_mem[ab_rd_addr];
`ifdef NTT_MUL_ACC_EN
      h_rd_data    <= h_mem[ab_rd_addr];
`endif
    end
  end

  ntt_mul_scheduler #(.MUL_LAT(MUL_LAT)) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .busy         (busy),
    .done         (done),
    .ab_rd_en     (ab_rd_en),
    .ab_rd_addr   (ab_rd_addr),
    .f_rd_data    (f_rd_data),
    .g_rd_data    (g_rd_data),
    .zeta_rd_data (zeta_rd_data),
`ifdef NTT_MUL_ACC_EN
    .acc          (acc),
    .h_rd_data    (h_rd_data),
`endif
    .h_wr_valid   (h_wr_valid),
    .h_wr_ready   (h_wr_ready),
    .h_wr_addr    (h_wr_addr),
    .h_wr_data    (h_wr_data)
  );

  function automatic logic [31:0] model(input logic [31:0] f, input logic [31:0] g,
                                        input logic [15:0] z, input logic [31:0] hold, input bit accm);
    longint f0, f1, g0, g1, zz, h0, h1;
    f0 = longint'(f[15:0]);  f1 = longint'(f[31:16]);
    g0 = longint'(g[15:0]);  g1 = longint'(g[31:16]);
    zz = longint'(z);
    h0 = (f0 * g0 + f1 * g1 * zz) % Q;
    h1 = (f0 * g1 + f1 * g0) % Q;
    if (accm) begin
      h0 = (h0 + longint'(hold[15:0])) % Q;
      h1 = (h1 + longint'(hold[31:16])) % Q;
    end
    return {16'(h1), 16'(h0)};
  endfunction

  function automatic int gamma_of(input int i);
    int     r;
    longint p;
    r = 0;
    p = 1;
    for (int b = 0; b < 7; b++) if (((i >> b) & 1) == 1) r = r | (1 << (6 - b));
    for (int e = 0; e < 2 * r + 1; e++) p = (p * 17) % Q;
    return int'(p);
  endfunction

  task automatic load_sb(input bit accm);
    logic [31:0] hold;
    for (int i = 0; i < 128; i++) begin
      hold = '0;
`ifdef NTT_MUL_ACC_EN
      hold = h_mem[i];
`endif
      sb_q.push_back('{addr: i, data: model(f_mem[i], g_mem[i], z_mem[i], hold, accm)});
      h_got[i] = 32'hDEAD_BEEF;
    end
  endtask

  function automatic logic [31:0] rnd_pair();
    return {16'($urandom_range(0, Q - 1)), 16'($urandom_range(0, Q - 1))};
  endfunction

  // Drives one pass; mode 1 applies the T4 ready pattern. Scoreboard compares every accepted write.
  task automatic run_pass(input int mode, input bit acc_i, output int n_wr, output int done_cyc,
                          output int first_wr, output logic busy1);
    exp_t e;
    n_wr = 0; done_cyc = -1; first_wr = -1; busy1 = 1'b0;
    @(negedge clk);
    start = 1'b1;
    h_wr_ready = 1'b1;
`ifdef NTT_MUL_ACC_EN
    acc = acc_i;
`else
    if (acc_i) $display("note: acc ignored in this build");
`endif
    for (int c = 1; c <= 4000; c++) begin
      @(negedge clk);
      start = 1'b0;
      if (c == 1) busy1 = busy;
      h_wr_ready = (mode == 1) ? !((c >= 20 && c <= 29) || (c > 100 && (c % 2) == 1)) : 1'b1;
      if (h_wr_valid && h_wr_ready) begin
        if (first_wr < 0) first_wr = c;
        n_wr++;
        h_got[h_wr_addr] = h_wr_data;
        checks++;
        if (sb_q.size() == 0) begin
          failures++;
          $display("FAIL unexpected_write addr=%0d data=%h required=none", h_wr_addr, h_wr_data);
        end else begin
          e = sb_q.pop_front();
          if (h_wr_addr !== 7'(e.addr)) begin
            failures++;
            $display("FAIL wr_addr got=%0d required=%0d", h_wr_addr, e.addr);
          end
          checks++;
          if (h_wr_data !== e.data) begin
            failures++;
            $display("FAIL wr_data addr=%0d got=%h required=%h", e.addr, h_wr_data, e.data);
          end
        end
      end
      if (done) begin
        done_cyc = c;
        break;
      end
    end
    h_wr_ready = 1'b1;
    checks++;
    if (done_cyc < 0) begin
      failures++;
      $display("FAIL pass_timeout done=%0b required=1 within 4000 cycles", done);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    checks += 7;
    if (busy !== 1'b0)       begin failures++; $display("FAIL rst_busy got=%b required=0", busy); end
    if (done !== 1'b0)       begin failures++; $display("FAIL rst_done got=%b required=0", done); end
    if (ab_rd_en !== 1'b0)   begin failures++; $display("FAIL rst_rd_en got=%b required=0", ab_rd_en); end
    if (h_wr_valid !== 1'b0) begin failures++; $display("FAIL rst_wr_valid got=%b required=0", h_wr_valid); end
    if (ab_rd_addr !== 7'd0) begin failures++; $display("FAIL rst_rd_addr got=%0d required=0", ab_rd_addr); end
    if (h_wr_addr !== 7'd0)  begin failures++; $display("FAIL rst_wr_addr got=%0d required=0", h_wr_addr); end
    if (h_wr_data !== 32'd0) begin failures++; $display("FAIL rst_wr_data got=%h required=0", h_wr_data); end
    rst = 1'b0;
  endtask

  task automatic test_directed();
    int n, dc, fw;
    logic b1;
    for (int i = 0; i < 128; i++) begin f_mem[i] = '0; g_mem[i] = '0; z_mem[i] = 16'd17; end
    f_mem[0] = 32'h0000_0001; g_mem[0] = 32'h0007_0005;
    f_mem[3] = 32'h0001_0000; g_mem[3] = 32'h0001_0000;
    f_mem[5] = 32'h0001_0000; g_mem[5] = 32'h0001_0000; z_mem[5] = 16'd3312;
    load_sb(1'b0);
    run_pass(0, 1'b0, n, dc, fw, b1);
    checks += 8;
    if (b1 !== 1'b1)   begin failures++; $display("FAIL busy_cycle1 got=%b required=1", b1); end
    if (fw != 2 + MUL_LAT) begin failures++; $display("FAIL first_write_cycle got=%0d required=%0d", fw, 2 + MUL_LAT); end
    if (dc != 130 + MUL_LAT) begin failures++; $display("FAIL done_cycle got=%0d required=%0d", dc, 130 + MUL_LAT); end
    if (n != 128)      begin failures++; $display("FAIL write_count got=%0d required=128", n); end
    if (h_got[0] !== 32'h0007_0005) begin failures++; $display("FAIL t1_pair0 got=%h required=00070005", h_got[0]); end
    if (h_got[3] !== 32'h0000_0011) begin failures++; $display("FAIL t2_pair3 got=%h required=00000011", h_got[3]); end
    if (h_got[5] !== 32'h0000_0CF0) begin failures++; $display("FAIL t2_neg_gamma got=%h required=00000cf0", h_got[5]); end
    if (sb_q.size() != 0) begin failures++; $display("FAIL sb_left got=%0d required=0", sb_q.size()); end
    @(negedge clk);
    checks += 2;
    if (done !== 1'b0) begin failures++; $display("FAIL done_pulse got=%b required=0", done); end
    if (busy !== 1'b0) begin failures++; $display("FAIL busy_after got=%b required=0", busy); end
  endtask

  task automatic test_max();
    int n, dc, fw, bad;
    logic b1;
    for (int i = 0; i < 128; i++) begin f_mem[i] = 32'h0D00_0D00; g_mem[i] = 32'h0D00_0D00; z_mem[i] = 16'd17; end
    load_sb(1'b0);
    run_pass(0, 1'b0, n, dc, fw, b1);
    bad = 0;
    for (int i = 0; i < 128; i++) if (h_got[i] !== 32'h0002_0012) bad++;
    checks += 2;
    if (bad != 0) begin failures++; $display("FAIL t3_max bad_pairs=%0d required=0 h0=%h", bad, h_got[0]); end
    if (n != 128) begin failures++; $display("FAIL t3_count got=%0d required=128", n); end
  endtask

  task automatic test_backpressure();
    int n, dc, fw;
    logic b1;
    for (int i = 0; i < 128; i++) begin f_mem[i] = rnd_pair(); g_mem[i] = rnd_pair(); z_mem[i] = 16'(gamma_of(i)); end
    load_sb(1'b0);
    run_pass(1, 1'b0, n, dc, fw, b1);
    checks += 3;
    if (n != 128) begin failures++; $display("FAIL t4_count got=%0d required=128", n); end
    if (sb_q.size() != 0) begin failures++; $display("FAIL t4_sb_left got=%0d required=0", sb_q.size()); end
    if (dc <= 130 + MUL_LAT) begin failures++; $display("FAIL t4_done_late got=%0d required>%0d", dc, 130 + MUL_LAT); end
  endtask

  task automatic test_rst_mid();
    int late;
    for (int i = 0; i < 128; i++) begin f_mem[i] = rnd_pair(); g_mem[i] = rnd_pair(); end
    @(negedge clk);
    start = 1'b1;
    for (int c = 1; c <= 60; c++) begin
      @(negedge clk);
      start = 1'b0;
      if (c == 60) rst = 1'b1;
    end
    @(negedge clk);
    rst = 1'b0;
    checks += 2;
    if (busy !== 1'b0)       begin failures++; $display("FAIL t5_busy got=%b required=0", busy); end
    if (h_wr_valid !== 1'b0) begin failures++; $display("FAIL t5_valid got=%b required=0", h_wr_valid); end
    late = 0;
    for (int c = 0; c < 150; c++) begin
      @(negedge clk);
      if (h_wr_valid || busy || done) late++;
    end
    checks++;
    if (late != 0) begin failures++; $display("FAIL t5_activity got=%0d required=0", late); end
  endtask

  task automatic test_back_to_back();
    int n, dc, fw;
    logic b1;
    for (int p = 0; p < 2; p++) begin
      for (int i = 0; i < 128; i++) begin f_mem[i] = rnd_pair(); g_mem[i] = rnd_pair(); z_mem[i] = 16'(gamma_of(i)); end
      load_sb(1'b0);
      run_pass(0, 1'b0, n, dc, fw, b1);
      checks += 3;
      if (n != 128) begin failures++; $display("FAIL b2b_count pass=%0d got=%0d required=128", p, n); end
      if (dc != 130 + MUL_LAT) begin failures++; $display("FAIL b2b_done pass=%0d got=%0d required=%0d", p, dc, 130 + MUL_LAT); end
      if (sb_q.size() != 0) begin failures++; $display("FAIL b2b_sb_left pass=%0d got=%0d required=0", p, sb_q.size()); end
    end
  endtask

`ifdef NTT_MUL_ACC_EN
  task automatic test_acc();
    int n, dc, fw;
    logic b1;
    for (int i = 0; i < 128; i++) begin
      f_mem[i] = 32'h0000_0001; g_mem[i] = 32'h01F4_01F4; z_mem[i] = 16'd17; h_mem[i] = 32'h0BB8_0BB8;
    end
    load_sb(1'b1);
    run_pass(0, 1'b1, n, dc, fw, b1);
    checks++;
    if (h_got[0] !== 32'h00AB_00AB) begin failures++; $display("FAIL t6_acc1 got=%h required=00ab00ab", h_got[0]); end
    load_sb(1'b0);
    run_pass(0, 1'b0, n, dc, fw, b1);
    checks++;
    if (h_got[0] !== 32'h01F4_01F4) begin failures++; $display("FAIL t6_acc0 got=%h required=01f401f4", h_got[0]); end
  endtask
`endif

  initial begin
    test_reset();
    test_directed();
    test_max();
    test_backpressure();
    test_rst_mid();
    test_back_to_back();
`ifdef NTT_MUL_ACC_EN
    test_acc();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
